// File: rtl/canvas_mem_arbiter.sv
// canvas_mem_arbiter: shares the canvas VRAM system-side port between the
// write-only drawing engine (requester A) and the read/write host (requester B).
// Arbitration is owner-hold with a bounded hold count. Memory controls are
// registered and B's read data comes back in order with a fixed latency.
// Optional feature macro: ARB_STATS_EN adds transfer/wait statistics counters
// and a synchronous stat_clr input.
module canvas_mem_arbiter #(
  parameter int ADDRW    = 16,
  parameter int DATAW    = 4,
  parameter int RAM_LAT  = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [ADDRW-1:0] a_addr,
  input  logic [DATAW-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_we,
  input  logic [ADDRW-1:0] b_addr,
  input  logic [DATAW-1:0] b_data,
  output logic             b_rvalid,
  output logic [DATAW-1:0] b_rdata,
  output logic             mem_we,
  output logic             mem_re,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_din,
  input  logic [DATAW-1:0] mem_dout,
  output logic             busy
`ifdef ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_a_cnt,
  output logic [31:0]      stat_b_cnt,
  output logic [31:0]      stat_wait_cnt
`endif
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  owner_t             owner;
  logic [7:0]         hold_cnt;
  logic               own_valid;
  logic               oth_valid;
  logic               grant_own;
  logic               grant_oth;
  logic               a_fire;
  logic               b_fire;
  logic [RAM_LAT-1:0] rd_pipe;

  // Grant decision: the owner keeps the port until its hold budget runs out
  // while the other side waits; an idle owner hands over with no bubble.
  always_comb begin
    own_valid = (owner == OWN_A) ? a_valid : b_valid;
    oth_valid = (owner == OWN_A) ? b_valid : a_valid;
    grant_own = own_valid && ((hold_cnt < MAX_HOLD_C) || !oth_valid);
    grant_oth = !grant_own && oth_valid;
    a_ready   = (owner == OWN_A) ? grant_own : grant_oth;
    b_ready   = (owner == OWN_A) ? grant_oth : grant_own;
  end

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  // Owner/hold state: count consecutive owner grants (saturating), restart at
  // one when ownership flips, and clear when nobody is granted.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      owner    <= OWN_A;
      hold_cnt <= 8'd0;
    end else if (grant_own) begin
      hold_cnt <= (hold_cnt < MAX_HOLD_C) ? hold_cnt + 8'd1 : MAX_HOLD_C;
    end else if (grant_oth) begin
      owner    <= (owner == OWN_A) ? OWN_B : OWN_A;
      hold_cnt <= 8'd1;
    end else begin
      hold_cnt <= 8'd0;
    end
  end

  // Memory issue: register the granted transfer onto the VRAM port one cycle
  // after the handshake; address and data hold when nothing is issued.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_we <= a_fire || (b_fire && b_we);
      mem_re <= b_fire && !b_we;
      if (a_fire) begin
        mem_addr <= a_addr;
        mem_din  <= a_data;
      end else if (b_fire) begin
        mem_addr <= b_addr;
        mem_din  <= b_we ? b_data : '0;
      end
    end
  end

  // Read return: a token shifts alongside the VRAM latency so mem_dout is
  // captured exactly when the read issued RAM_LAT cycles earlier is valid.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      rd_pipe  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      rd_pipe[0] <= mem_re;
      for (int i = 1; i < RAM_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      b_rvalid <= rd_pipe[RAM_LAT-1];
      if (rd_pipe[RAM_LAT-1]) begin
        b_rdata <= mem_dout;
      end
    end
  end

  assign busy = mem_we || mem_re || (|rd_pipe);

`ifdef ARB_STATS_EN
  logic wait_now;

  assign wait_now = (a_valid && !a_ready) || (b_valid && !b_ready);

  // Statistics: saturating per-requester transfer counts and waiting cycles;
  // a clear request wins over any increment in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (rst_sys || stat_clr) begin
      stat_a_cnt    <= 32'd0;
      stat_b_cnt    <= 32'd0;
      stat_wait_cnt <= 32'd0;
    end else begin
      if (a_fire && (stat_a_cnt != 32'hFFFF_FFFF)) begin
        stat_a_cnt <= stat_a_cnt + 32'd1;
      end
      if (b_fire && (stat_b_cnt != 32'hFFFF_FFFF)) begin
        stat_b_cnt <= stat_b_cnt + 32'd1;
      end
      if (wait_now && (stat_wait_cnt != 32'hFFFF_FFFF)) begin
        stat_wait_cnt <= stat_wait_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
